pp_loop_monitor: RTL and testbench
==================================

# pp_loop_monitor

Synthesizable run-time monitor that observes one HLS-generated block: its top-level ap_ctrl handshake and one pipelined loop inside its FSM. It counts transactions, loop invocations, iterations, active and stall cycles, and flags protocol anomalies. It sits beside the design under observation as a passive tap, driving nothing back into it. Counters freeze on `finish` for readout.

## Interface
- `STATE_W`, default 104: width of the one-hot `ap_CS_fsm` vector and of each state constant.
- `CNT_W`, default 32: width of every counter; counters saturate at all-ones.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-high; clears all state.
- `finish`  in  1: end of simulation/run; freezes counters.
- `ap_start`, `ap_ready`, `ap_done`, `ap_continue`  in  1 each: module handshake.
- `cur_state`  in  STATE_W: one-hot current FSM state.
- `pre_loop_state0`, `post_loop_state0`  in  STATE_W: one-hot state constants bracketing the loop.
- `pre_states_valid`, `post_states_valid`  in  1: qualify these constants.
- `iter_start_state`, `iter_end_state`, `loop_quit_state`  in  STATE_W: pipeline stage state constants.
- `iter_start_enable`, `iter_end_enable`  in  1: `ap_enable_reg_pp0_iter0` and `ap_enable_reg_pp0_iterN`.
- `iter_start_block`, `iter_end_block`  in  1: `ap_block_pp0_stage0_subdone`.
- `quit_at_end`  in  1: loop exits only after the last iteration drains.
- `mod_state`  out  2: 0 IDLE, 1 BUSY, 2 DONE_WAIT.
- `mod_starts`, `mod_dones`, `mod_busy_cycles`  out  CNT_W each.
- `loop_active`  out  1.
- `loop_invocations`, `iter_started`, `iter_ended`, `loop_cycles`, `stall_cycles`  out  CNT_W each.
- `in_flight`  out  CNT_W: `iter_started - iter_ended`.
- `err_flag`  out  1: sticky protocol error.
- `frozen`  out  1: counters frozen.
- `dump_valid`  out  1: one-cycle pulse when the freeze takes effect.

## Operation
- State match: `in(X)` means `(cur_state & X) != 0`. Pre and post matches are additionally ANDed with their valid bits.

Module FSM:
- IDLE -> BUSY when `ap_start`; `mod_starts++`.
- BUSY -> IDLE when `ap_done && ap_continue`; BUSY -> DONE_WAIT when `ap_done && !ap_continue`.
- DONE_WAIT -> IDLE when `ap_continue`.
- Each `ap_done && ap_continue` increments `mod_dones`. A start and a done in the same cycle count both, and the FSM goes to BUSY if `ap_start` is high, otherwise IDLE.
- `mod_busy_cycles++` every cycle the FSM is not IDLE.

Loop FSM:
- A registered flag `prev_pre` holds `in(pre_loop_state0)` from the previous cycle.
- L_IDLE -> L_ACTIVE when `prev_pre && in(iter_start_state)`; `loop_invocations++`.
- In L_ACTIVE:
  - Iteration start when `in(iter_start_state) && iter_start_enable && !iter_start_block`; `iter_started++`.
  - Iteration end when `in(iter_end_state) && iter_end_enable && !iter_end_block`; `iter_ended++`.
  - Both may occur in the same cycle.
  - `loop_cycles++` every cycle.
  - `stall_cycles++` when `in(iter_start_state) && iter_start_block`.
- L_ACTIVE -> L_IDLE when `in(post_loop_state0)`.
- If `quit_at_end` and `in_flight != 0` at that exit, set `err_flag`.
- Errors: `ap_done` while IDLE sets `err_flag`, as does an iteration end that would make `in_flight` negative; in the latter case `iter_ended` is not incremented.
- Finish: the first cycle `finish` is sampled high sets `frozen`. From then on no counter or FSM updates; `dump_valid` pulses on the following cycle. Only `reset` clears `frozen`.

## Timing
- All outputs are registered. Each event is reflected one cycle after the sampling edge.
- Reset values: every counter 0, `mod_state` IDLE, `loop_active` 0, `err_flag` 0, `frozen` 0, `dump_valid` 0.
- Reset has priority over `finish` and over every event. Reset mid-loop or mid-transaction discards everything with no error.
- Counter saturation: a counter at all-ones stays at all-ones. `in_flight` is computed from the saturated values.
- Zero-latency entry: a loop whose first start-state cycle has its iteration start counts the invocation and the iteration in the same cycle.

## Structure
- Shared package `pp_loop_mon_pkg`: module-state enum (IDLE/BUSY/DONE_WAIT), loop-state enum (L_IDLE/L_ACTIVE), and a saturating-increment function parameterized on `CNT_W`.
- Natural sub-module: `nodf_status_tracker`, the module handshake FSM plus `mod_*` counters, instantiated once inside `pp_loop_monitor`.

## Test plan
- Handshake: `ap_start` 1 cycle, `ap_done` 5 cycles later with `ap_continue=1` -> `mod_starts=1`, `mod_dones=1`, `mod_busy_cycles=6`, state IDLE.
- Continue backpressure: `ap_done` with `ap_continue=0` for 3 cycles, then 1 -> state DONE_WAIT for 3 cycles, `mod_dones=1` only after `continue`.
- Pipelined loop: pre state, then 8 unblocked start-enable cycles, end-enable lagging 3 cycles, then post state -> `loop_invocations=1`, `iter_started=8`, `iter_ended=8`, `err_flag=0`.
- Stall: same loop with `iter_start_block=1` for 4 cycles mid-loop -> `stall_cycles=4`, `loop_cycles` 4 larger than the unstalled run, iteration counts unchanged.
- Early quit: post state reached with `in_flight=2`, `quit_at_end=1` -> `err_flag=1`, `loop_active=0`.
- Finish and reset: `finish` high mid-loop -> counters frozen, `dump_valid` pulses once the next cycle; subsequent `reset` -> all outputs 0.

Source files
------------

// File: rtl/pp_loop_mon_pkg.sv
// Shared types and helpers for the pipelined-loop run-time monitor.
package pp_loop_mon_pkg;

  // Top-level ap_ctrl transaction state as seen by the monitor.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } mod_state_e;

  // Whether the observed pipelined loop is currently running.
  typedef enum logic {
    L_IDLE   = 1'b0,
    L_ACTIVE = 1'b1
  } loop_state_e;

  // Widest counter the saturating helper supports.
  localparam int SAT_MAX_W = 64;

  // Saturating increment for a counter of cnt_w bits, carried zero-extended in
  // a SAT_MAX_W container. A value already at the cnt_w-bit all-ones stays put.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                   input int cnt_w);
    logic [SAT_MAX_W-1:0] max_val;
    max_val = (cnt_w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << cnt_w) - SAT_MAX_W'(1));
    return (value >= max_val) ? max_val : value + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pp_loop_monitor_status_tracker.sv
// Module-level ap_ctrl handshake tracker: transaction FSM plus start/done/busy
// counters. Updates only while enable is high so the parent can freeze it.
module nodf_status_tracker
  import pp_loop_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             ap_start,
  input  logic             ap_done,
  input  logic             ap_continue,
  output mod_state_e       state,
  output logic [CNT_W-1:0] starts,
  output logic [CNT_W-1:0] dones,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             done_in_idle
);

  mod_state_e state_nxt;
  logic       start_evt;
  logic       done_evt;
  logic       busy_evt;

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] value);
    return CNT_W'(sat_inc(SAT_MAX_W'(value), CNT_W));
  endfunction

  // Next-state and event decode. A done accepted together with a new start
  // chains straight into the next transaction.
  always_comb begin
    state_nxt    = state;
    start_evt    = 1'b0;
    done_evt     = 1'b0;
    done_in_idle = 1'b0;
    unique case (state)
      IDLE: begin
        done_in_idle = ap_done;
        if (ap_start) begin
          state_nxt = BUSY;
          start_evt = 1'b1;
        end
      end
      BUSY: begin
        if (ap_done && ap_continue) begin
          done_evt = 1'b1;
          if (ap_start) begin
            state_nxt = BUSY;
            start_evt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (ap_done) begin
          state_nxt = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (ap_continue) begin
          done_evt = ap_done;
          if (ap_start) begin
            state_nxt = BUSY;
            start_evt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The cycle in which a start is accepted already belongs to the transaction.
    busy_evt = (state != IDLE) || start_evt;
  end

  // State register and saturating counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      starts      <= '0;
      dones       <= '0;
      busy_cycles <= '0;
    end else if (enable) begin
      state <= state_nxt;
      if (start_evt) starts      <= inc(starts);
      if (done_evt)  dones       <= inc(dones);
      if (busy_evt)  busy_cycles <= inc(busy_cycles);
    end
  end

endmodule

// File: rtl/pp_loop_monitor.sv
// Passive run-time monitor for one HLS block: tracks the ap_ctrl handshake and
// one pipelined loop inside the block FSM, counts activity, and flags anomalies.
// Handshake: the monitor only samples; an ap_ctrl transaction is accepted on a
// cycle with ap_start high in IDLE, and completes on a cycle with ap_done and
// ap_continue both high. Nothing is driven back toward the observed block.
module pp_loop_monitor
  import pp_loop_mon_pkg::*;
#(
  parameter int STATE_W = 104,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state0,
  input  logic [STATE_W-1:0] post_loop_state0,
  input  logic               pre_states_valid,
  input  logic               post_states_valid,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] loop_quit_state,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_at_end,
  output logic [1:0]         mod_state,
  output logic [CNT_W-1:0]   mod_starts,
  output logic [CNT_W-1:0]   mod_dones,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_invocations,
  output logic [CNT_W-1:0]   iter_started,
  output logic [CNT_W-1:0]   iter_ended,
  output logic [CNT_W-1:0]   loop_cycles,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   in_flight,
  output logic               err_flag,
  output logic               frozen,
  output logic               dump_valid
);

  // ap_ready and the quit-state constant carry no information the counters need.
  logic unused_inputs;
  assign unused_inputs = ap_ready ^ (|loop_quit_state);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] value);
    return CNT_W'(sat_inc(SAT_MAX_W'(value), CNT_W));
  endfunction

  // Counters and FSMs advance only before freeze and not in the freezing cycle.
  logic run;
  assign run = !frozen && !finish;

  mod_state_e trk_state;
  logic       done_in_idle;

  nodf_status_tracker #(
    .CNT_W (CNT_W)
  ) u_status (
    .clock        (clock),
    .reset        (reset),
    .enable       (run),
    .ap_start     (ap_start),
    .ap_done      (ap_done),
    .ap_continue  (ap_continue),
    .state        (trk_state),
    .starts       (mod_starts),
    .dones        (mod_dones),
    .busy_cycles  (mod_busy_cycles),
    .done_in_idle (done_in_idle)
  );

  assign mod_state = trk_state;

  // State membership tests against the one-hot FSM vector.
  logic in_pre, in_post, in_start, in_end;
  assign in_pre   = pre_states_valid  && |(cur_state & pre_loop_state0);
  assign in_post  = post_states_valid && |(cur_state & post_loop_state0);
  assign in_start = |(cur_state & iter_start_state);
  assign in_end   = |(cur_state & iter_end_state);

  loop_state_e      lstate, lstate_nxt;
  logic             prev_pre;
  logic             enter, live, exit_loop;
  logic             start_evt, end_req, underflow, early_quit, stall_evt, err_evt;
  logic [CNT_W-1:0] started_nxt, ended_nxt;

  assign loop_active = (lstate == L_ACTIVE);

  // Loop FSM next state and per-cycle events. The entry cycle is already live so
  // an iteration issued on the first start-state cycle is counted with it.
  always_comb begin
    lstate_nxt  = lstate;
    enter       = (lstate == L_IDLE) && prev_pre && in_start;
    live        = (lstate == L_ACTIVE) || enter;
    exit_loop   = (lstate == L_ACTIVE) && in_post;
    start_evt   = live && in_start && iter_start_enable && !iter_start_block;
    stall_evt   = live && in_start && iter_start_block;
    started_nxt = start_evt ? inc(iter_started) : iter_started;
    end_req     = live && in_end && iter_end_enable && !iter_end_block;
    // An end with nothing in flight is dropped rather than counted.
    underflow   = end_req && (iter_ended >= started_nxt);
    ended_nxt   = (end_req && !underflow) ? inc(iter_ended) : iter_ended;
    early_quit  = exit_loop && quit_at_end && (started_nxt != ended_nxt);
    err_evt     = done_in_idle || underflow || early_quit;
    if (enter) begin
      lstate_nxt = L_ACTIVE;
    end else if (exit_loop) begin
      lstate_nxt = L_IDLE;
    end
  end

  // Loop FSM register, loop counters, sticky error and freeze control.
  always_ff @(posedge clock) begin
    if (reset) begin
      lstate           <= L_IDLE;
      prev_pre         <= 1'b0;
      loop_invocations <= '0;
      iter_started     <= '0;
      iter_ended       <= '0;
      loop_cycles      <= '0;
      stall_cycles     <= '0;
      in_flight        <= '0;
      err_flag         <= 1'b0;
      frozen           <= 1'b0;
      dump_valid       <= 1'b0;
    end else begin
      dump_valid <= finish && !frozen;
      if (finish) frozen <= 1'b1;
      if (run) begin
        lstate       <= lstate_nxt;
        prev_pre     <= in_pre;
        iter_started <= started_nxt;
        iter_ended   <= ended_nxt;
        in_flight    <= started_nxt - ended_nxt;
        if (enter)     loop_invocations <= inc(loop_invocations);
        if (live)      loop_cycles      <= inc(loop_cycles);
        if (stall_evt) stall_cycles     <= inc(stall_cycles);
        if (err_evt)   err_flag         <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pp_loop_monitor.sv
// Directed bench for pp_loop_monitor: handshake, backpressure, pipelined loop,
// stall, early quit, underflow, zero-latency entry, finish/freeze and reset.
module tb_pp_loop_monitor;

  localparam int STATE_W = 104;
  localparam int CNT_W   = 32;
  localparam int OTHER_B = 0;
  localparam int PRE_B   = 3;
  localparam int START_B = 10;
  localparam int POST_B  = 20;

  logic               clock = 1'b0;
  logic               reset, finish;
  logic               ap_start, ap_ready, ap_done, ap_continue;
  logic [STATE_W-1:0] cur_state, pre_loop_state0, post_loop_state0;
  logic               pre_states_valid, post_states_valid;
  logic [STATE_W-1:0] iter_start_state, iter_end_state, loop_quit_state;
  logic               iter_start_enable, iter_end_enable;
  logic               iter_start_block, iter_end_block, quit_at_end;
  logic [1:0]         mod_state;
  logic [CNT_W-1:0]   mod_starts, mod_dones, mod_busy_cycles;
  logic               loop_active;
  logic [CNT_W-1:0]   loop_invocations, iter_started, iter_ended;
  logic [CNT_W-1:0]   loop_cycles, stall_cycles, in_flight;
  logic               err_flag, frozen, dump_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  pp_loop_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .finish            (finish),
    .ap_start          (ap_start),
    .ap_ready          (ap_ready),
    .ap_done           (ap_done),
    .ap_continue       (ap_continue),
    .cur_state         (cur_state),
    .pre_loop_state0   (pre_loop_state0),
    .post_loop_state0  (post_loop_state0),
    .pre_states_valid  (pre_states_valid),
    .post_states_valid (post_states_valid),
    .iter_start_state  (iter_start_state),
    .iter_end_state    (iter_end_state),
    .loop_quit_state   (loop_quit_state),
    .iter_start_enable (iter_start_enable),
    .iter_end_enable   (iter_end_enable),
    .iter_start_block  (iter_start_block),
    .iter_end_block    (iter_end_block),
    .quit_at_end       (quit_at_end),
    .mod_state         (mod_state),
    .mod_starts        (mod_starts),
    .mod_dones         (mod_dones),
    .mod_busy_cycles   (mod_busy_cycles),
    .loop_active       (loop_active),
    .loop_invocations  (loop_invocations),
    .iter_started      (iter_started),
    .iter_ended        (iter_ended),
    .loop_cycles       (loop_cycles),
    .stall_cycles      (stall_cycles),
    .in_flight         (in_flight),
    .err_flag          (err_flag),
    .frozen            (frozen),
    .dump_valid        (dump_valid)
  );

  // Clock and reset block
  always #5 clock = ~clock;

  // One clock: inputs set before the call are sampled, outputs read #1 after.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_state(input int b);
    cur_state    = '0;
    cur_state[b] = 1'b1;
  endtask

  task automatic clear_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    iter_start_enable = 0; iter_end_enable = 0; iter_start_block = 0;
    iter_end_block = 0; set_state(OTHER_B);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  // Driver: pre state, loop body with ends lagging starts, then post state.
  // cut trims the tail so that iterations are still in flight at the exit.
  task automatic drive_loop(input int n_iter, input int lag, input int stall_at,
                            input int stall_len, input int cut);
    int   issued;
    int   total;
    logic hist [64];
    issued = 0;
    total  = n_iter + stall_len + lag - cut;
    for (int i = 0; i < 64; i++) hist[i] = 1'b0;
    set_state(PRE_B);
    step();
    for (int c = 0; c < total; c++) begin
      set_state(START_B);
      iter_start_enable = (issued < n_iter);
      iter_start_block  = (c >= stall_at) && (c < stall_at + stall_len);
      hist[c] = iter_start_enable && !iter_start_block;
      if (hist[c]) issued++;
      iter_end_enable = (c >= lag) ? hist[c - lag] : 1'b0;
      step();
    end
    iter_start_enable = 0; iter_start_block = 0; iter_end_enable = 0;
    set_state(POST_B);
    step();
    set_state(OTHER_B);
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (mod_state !== 2'd0) begin n_fail++; $display("FAIL rst_mod_state: got %0d want 0", mod_state); end
    n_cmp++; if (mod_starts !== '0 || mod_dones !== '0 || mod_busy_cycles !== '0) begin n_fail++; $display("FAIL rst_mod_cnt: got %0d/%0d/%0d want 0/0/0", mod_starts, mod_dones, mod_busy_cycles); end
    n_cmp++; if (loop_invocations !== '0 || iter_started !== '0 || iter_ended !== '0 || loop_cycles !== '0 || stall_cycles !== '0 || in_flight !== '0) begin n_fail++; $display("FAIL rst_loop_cnt: got nonzero loop counters"); end
    n_cmp++; if ({loop_active, err_flag, frozen, dump_valid} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {loop_active, err_flag, frozen, dump_valid}); end
  endtask

  task automatic test_handshake();
    do_reset();
    ap_start = 1; step(); ap_start = 0;
    n_cmp++; if (mod_state !== 2'd1) begin n_fail++; $display("FAIL hs_busy: got %0d want 1", mod_state); end
    repeat (4) step();
    ap_done = 1; ap_continue = 1; step(); ap_done = 0; ap_continue = 0;
    n_cmp++; if (mod_starts !== 32'd1) begin n_fail++; $display("FAIL hs_starts: got %0d want 1", mod_starts); end
    n_cmp++; if (mod_dones !== 32'd1) begin n_fail++; $display("FAIL hs_dones: got %0d want 1", mod_dones); end
    n_cmp++; if (mod_busy_cycles !== 32'd6) begin n_fail++; $display("FAIL hs_busy_cycles: got %0d want 6", mod_busy_cycles); end
    n_cmp++; if (mod_state !== 2'd0) begin n_fail++; $display("FAIL hs_idle: got %0d want 0", mod_state); end
    // A done with no transaction open is a protocol error.
    ap_done = 1; ap_continue = 1; step(); ap_done = 0; ap_continue = 0;
    n_cmp++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL hs_idle_done_err: got %b want 1", err_flag); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ap_start = 1; step(); ap_start = 0;
    repeat (2) step();
    ap_done = 1; ap_continue = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (mod_state !== 2'd2) begin n_fail++; $display("FAIL bp_wait_%0d: got %0d want 2", i, mod_state); end
      n_cmp++; if (mod_dones !== 32'd0) begin n_fail++; $display("FAIL bp_dones_early_%0d: got %0d want 0", i, mod_dones); end
    end
    ap_continue = 1; step(); ap_done = 0; ap_continue = 0;
    n_cmp++; if (mod_state !== 2'd0) begin n_fail++; $display("FAIL bp_idle: got %0d want 0", mod_state); end
    n_cmp++; if (mod_dones !== 32'd1) begin n_fail++; $display("FAIL bp_dones: got %0d want 1", mod_dones); end
    n_cmp++; if (mod_busy_cycles !== 32'd7) begin n_fail++; $display("FAIL bp_busy_cycles: got %0d want 7", mod_busy_cycles); end
  endtask

  task automatic test_pipelined_loop();
    do_reset();
    drive_loop(8, 3, 0, 0, 0);
    n_cmp++; if (loop_invocations !== 32'd1) begin n_fail++; $display("FAIL pl_invocations: got %0d want 1", loop_invocations); end
    n_cmp++; if (iter_started !== 32'd8 || iter_ended !== 32'd8) begin n_fail++; $display("FAIL pl_iters: got %0d/%0d want 8/8", iter_started, iter_ended); end
    n_cmp++; if (loop_cycles !== 32'd12) begin n_fail++; $display("FAIL pl_loop_cycles: got %0d want 12", loop_cycles); end
    n_cmp++; if (stall_cycles !== 32'd0 || in_flight !== 32'd0) begin n_fail++; $display("FAIL pl_stall_inflight: got %0d/%0d want 0/0", stall_cycles, in_flight); end
    n_cmp++; if (err_flag !== 1'b0 || loop_active !== 1'b0) begin n_fail++; $display("FAIL pl_flags: got err=%b active=%b want 0/0", err_flag, loop_active); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_loop(8, 3, 3, 4, 0);
    n_cmp++; if (stall_cycles !== 32'd4) begin n_fail++; $display("FAIL st_stall_cycles: got %0d want 4", stall_cycles); end
    n_cmp++; if (loop_cycles !== 32'd16) begin n_fail++; $display("FAIL st_loop_cycles: got %0d want 16", loop_cycles); end
    n_cmp++; if (iter_started !== 32'd8 || iter_ended !== 32'd8) begin n_fail++; $display("FAIL st_iters: got %0d/%0d want 8/8", iter_started, iter_ended); end
    n_cmp++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL st_err: got %b want 0", err_flag); end
  endtask

  task automatic test_early_quit();
    do_reset();
    quit_at_end = 1;
    drive_loop(8, 3, 0, 0, 2);
    quit_at_end = 0;
    n_cmp++; if (iter_started !== 32'd8 || iter_ended !== 32'd6) begin n_fail++; $display("FAIL eq_iters: got %0d/%0d want 8/6", iter_started, iter_ended); end
    n_cmp++; if (in_flight !== 32'd2) begin n_fail++; $display("FAIL eq_in_flight: got %0d want 2", in_flight); end
    n_cmp++; if (err_flag !== 1'b1 || loop_active !== 1'b0) begin n_fail++; $display("FAIL eq_flags: got err=%b active=%b want 1/0", err_flag, loop_active); end
  endtask

  task automatic test_zero_latency();
    do_reset();
    // Start state without a preceding pre state must not open the loop.
    set_state(START_B); iter_start_enable = 1; step();
    n_cmp++; if (loop_active !== 1'b0 || iter_started !== 32'd0) begin n_fail++; $display("FAIL zl_no_pre: got active=%b started=%0d want 0/0", loop_active, iter_started); end
    iter_start_enable = 0; set_state(PRE_B); step();
    set_state(START_B); iter_start_enable = 1; step(); iter_start_enable = 0;
    n_cmp++; if (loop_invocations !== 32'd1 || iter_started !== 32'd1) begin n_fail++; $display("FAIL zl_entry: got inv=%0d started=%0d want 1/1", loop_invocations, iter_started); end
    n_cmp++; if (loop_active !== 1'b1 || in_flight !== 32'd1) begin n_fail++; $display("FAIL zl_active: got active=%b in_flight=%0d want 1/1", loop_active, in_flight); end
  endtask

  task automatic test_underflow();
    do_reset();
    set_state(PRE_B); step();
    set_state(START_B); step();
    iter_end_enable = 1; step(); iter_end_enable = 0;
    n_cmp++; if (iter_ended !== 32'd0 || err_flag !== 1'b1) begin n_fail++; $display("FAIL uf: got ended=%0d err=%b want 0/1", iter_ended, err_flag); end
    n_cmp++; if (in_flight !== 32'd0) begin n_fail++; $display("FAIL uf_in_flight: got %0d want 0", in_flight); end
  endtask

  task automatic test_finish_reset();
    do_reset();
    set_state(PRE_B); step();
    for (int c = 0; c < 5; c++) begin
      set_state(START_B);
      iter_start_enable = 1;
      iter_end_enable   = (c >= 3);
      step();
    end
    finish = 1; step();
    n_cmp++; if (frozen !== 1'b1 || dump_valid !== 1'b1) begin n_fail++; $display("FAIL fin_pulse: got frozen=%b dump=%b want 1/1", frozen, dump_valid); end
    n_cmp++; if (iter_started !== 32'd5 || iter_ended !== 32'd2 || in_flight !== 32'd3) begin n_fail++; $display("FAIL fin_iters: got %0d/%0d/%0d want 5/2/3", iter_started, iter_ended, in_flight); end
    n_cmp++; if (loop_cycles !== 32'd5 || loop_active !== 1'b1) begin n_fail++; $display("FAIL fin_loop: got cycles=%0d active=%b want 5/1", loop_cycles, loop_active); end
    finish = 0; ap_start = 1; step(); ap_start = 0;
    n_cmp++; if (dump_valid !== 1'b0 || frozen !== 1'b1) begin n_fail++; $display("FAIL fin_hold: got dump=%b frozen=%b want 0/1", dump_valid, frozen); end
    n_cmp++; if (iter_started !== 32'd5 || mod_starts !== 32'd0 || mod_state !== 2'd0) begin n_fail++; $display("FAIL fin_frozen_cnt: got started=%0d mod_starts=%0d state=%0d want 5/0/0", iter_started, mod_starts, mod_state); end
    // Reset wins over a simultaneous finish.
    reset = 1; finish = 1; step();
    reset = 0; finish = 0; iter_start_enable = 0; iter_end_enable = 0; set_state(OTHER_B); step();
    n_cmp++; if ({frozen, dump_valid, err_flag, loop_active} !== 4'b0000) begin n_fail++; $display("FAIL fin_rst_flags: got %b want 0000", {frozen, dump_valid, err_flag, loop_active}); end
    n_cmp++; if (iter_started !== '0 || iter_ended !== '0 || loop_cycles !== '0 || in_flight !== '0 || loop_invocations !== '0) begin n_fail++; $display("FAIL fin_rst_cnt: got started=%0d ended=%0d cycles=%0d", iter_started, iter_ended, loop_cycles); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    quit_at_end       = 0;
    pre_states_valid  = 1;
    post_states_valid = 1;
    pre_loop_state0   = '0; pre_loop_state0[PRE_B]   = 1'b1;
    post_loop_state0  = '0; post_loop_state0[POST_B] = 1'b1;
    iter_start_state  = '0; iter_start_state[START_B] = 1'b1;
    iter_end_state    = '0; iter_end_state[START_B]   = 1'b1;
    loop_quit_state   = '0; loop_quit_state[START_B]  = 1'b1;

    test_reset();
    test_handshake();
    test_backpressure();
    test_pipelined_loop();
    test_stall();
    test_early_quit();
    test_zero_latency();
    test_underflow();
    test_finish_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
